// File: rtl/t_ff_seq_ctrl.sv
// Sequencer that drives the T inputs of a WIDTH-bit T flip-flop bank so the bank acts as an
// up/down counter with terminal count, wrap/halt, parallel load and clear.
module t_ff_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic             cmd_wrap,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] q_vec,
    output logic [WIDTH-1:0] t_vec,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_APPLY} state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] ld_q, ld_d;
    logic             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;

    logic             accept;
    logic             at_tc;
    logic             carry;
    logic [WIDTH-1:0] cnt_mask;

    assign cmd_ready = (state_q == S_IDLE) | ((state_q == S_RUN) & (cmd_op == OP_STOP));
    assign accept    = cmd_valid & cmd_ready;
    assign at_tc     = (q_vec == tc_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    // Bit i toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        cnt_mask = '0;
        carry    = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_mask[i] = carry;
            carry       = carry & (q_vec[i] ~^ dir_q);
        end
    end

    always_comb begin
        state_d = state_q;
        tc_d    = tc_q;
        base_d  = base_q;
        ld_d    = ld_q;
        dir_d   = dir_q;
        wrap_d  = wrap_q;
        done_d  = 1'b0;
        t_vec   = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_START: begin
                            tc_d    = cmd_data;
                            dir_d   = cmd_dir;
                            wrap_d  = cmd_wrap;
                            base_d  = q_vec;
                            state_d = S_RUN;
                        end
                        OP_LOAD: begin
                            ld_d    = cmd_data;
                            state_d = S_APPLY;
                        end
                        OP_CLEAR: begin
                            ld_d    = '0;
                            state_d = S_APPLY;
                        end
                        default: ;
                    endcase
                end
            end
            S_APPLY: begin
                t_vec   = q_vec ^ ld_q;
                state_d = S_IDLE;
            end
            S_RUN: begin
                if (at_tc) begin
                    // Terminal count beats the count mask; a coincident STOP still ends the run.
                    done_d  = 1'b1;
                    t_vec   = wrap_q ? (q_vec ^ base_q) : '0;
                    state_d = (wrap_q && !accept) ? S_RUN : S_IDLE;
                end else begin
                    t_vec   = cnt_mask;
                    state_d = accept ? S_IDLE : S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tc_q    <= '1;
            base_q  <= '0;
            ld_q    <= '0;
            dir_q   <= 1'b1;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tc_q    <= tc_d;
            base_q  <= base_d;
            ld_q    <= ld_d;
            dir_q   <= dir_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_t_ff_seq_ctrl.sv
// Bench for t_ff_seq_ctrl: a 4-bit T flip-flop bank closed around the sequencer, checked against
// an arithmetic counter model (next value = q+1, q-1, base, tc or load value).
module tb_t_ff_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic       cmd_wrap;
    logic [3:0] cmd_data;
    logic [3:0] bank = 4'd0;
    logic [3:0] t_vec;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 running, 2 loading
    int         m_st;
    logic [3:0] m_q, m_tc, m_base, m_ld;
    logic       m_dir, m_wrap, m_done;
    logic [10:0] exp_v, got_v;

    t_ff_seq_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_wrap(cmd_wrap), .cmd_data(cmd_data),
        .q_vec(bank), .t_vec(t_vec), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // The T flip-flop bank itself (no reset)
    always @(posedge clk) bank <= bank ^ t_vec;

    function automatic logic [3:0] f_nq();
        if (m_st == 2) return m_ld;
        if (m_st == 1) begin
            if (m_q == m_tc) return m_wrap ? m_base : m_q;
            return m_dir ? m_q + 4'd1 : m_q - 4'd1;
        end
        return m_q;
    endfunction

    function automatic logic f_ready();
        return (m_st == 0) || (m_st == 1 && cmd_op == 2'b01);
    endfunction

    task automatic model_reset();
        m_st = 0; m_tc = 4'hF; m_dir = 1'b1; m_wrap = 1'b0; m_base = 4'h0; m_ld = 4'h0; m_done = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic dir, input logic wrap,
                         input logic [3:0] data);
        cmd_valid = v; cmd_op = op; cmd_dir = dir; cmd_wrap = wrap; cmd_data = data;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
    endtask

    // Advance one clock edge; the model follows the counter rules from the current inputs.
    task automatic step();
        logic [3:0] nq;
        logic acc, at;
        nq  = f_nq();
        acc = cmd_valid & f_ready();
        at  = (m_st == 1) && (m_q == m_tc);
        @(posedge clk);
        m_done = at;
        case (m_st)
            0: if (acc) begin
                if (cmd_op == 2'b00) begin
                    m_tc = cmd_data; m_dir = cmd_dir; m_wrap = cmd_wrap; m_base = m_q; m_st = 1;
                end else if (cmd_op == 2'b10) begin m_ld = cmd_data; m_st = 2; end
                else if (cmd_op == 2'b11) begin m_ld = 4'h0; m_st = 2; end
            end
            1: if (acc || (at && !m_wrap)) m_st = 0;
            default: m_st = 0;
        endcase
        m_q = nq;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        #1 rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if ({t_vec, cmd_ready, busy, done} !== 7'b0000_100) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got t=%h rdy=%b busy=%b done=%b exp t=0 rdy=1 busy=0 done=0",
                         c, t_vec, cmd_ready, busy, done);
            end
        end
        rst_n = 1'b1;
        model_reset();
        m_q = bank;
        #1;
        checks++;
        if ({t_vec, cmd_ready, busy, done} !== 7'b0000_100) begin
            errors++;
            $display("FAIL reset_release got t=%h rdy=%b busy=%b done=%b exp t=0 rdy=1 busy=0 done=0",
                     t_vec, cmd_ready, busy, done);
        end
        @(negedge clk);
    endtask

    task automatic test_clear();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1'b1, 2'b10, 1'b0, 1'b0, 4'b1010);
                2: drive(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
                default: idle();
            endcase
            #1;
            exp_v = {m_q ^ f_nq(), m_q, m_st != 0, m_done, f_ready()};
            got_v = {t_vec, bank, busy, done, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL clear cyc %0d got %h exp %h", c, got_v, exp_v);
            end
            if (c == 3) begin
                checks++;
                if ({t_vec, cmd_ready} !== 5'b1010_0) begin
                    errors++; $display("FAIL clear_apply got t=%b rdy=%b exp t=1010 rdy=0", t_vec, cmd_ready);
                end
            end
            step();
        end
        #1;
        checks++;
        if ({bank, t_vec} !== 8'h00) begin
            errors++; $display("FAIL clear_after got q=%b t=%b exp q=0000 t=0000", bank, t_vec);
        end
    endtask

    task automatic test_up_halt();
        int ndone = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'd5); else idle();
            #1;
            exp_v = {m_q ^ f_nq(), m_q, m_st != 0, m_done, f_ready()};
            got_v = {t_vec, bank, busy, done, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL up_halt cyc %0d got %h exp %h", c, got_v, exp_v);
            end
            if (done) ndone++;
            step();
        end
        checks++;
        if (bank !== 4'd5 || busy !== 1'b0 || ndone != 1) begin
            errors++; $display("FAIL up_halt_end got q=%0d busy=%b dones=%0d exp q=5 busy=0 dones=1", bank, busy, ndone);
        end
    endtask

    task automatic test_down_wrap();
        int ndone = 0;
        for (int c = 0; c < 15; c++) begin
            case (c)
                0: drive(1'b1, 2'b10, 1'b0, 1'b0, 4'd9);
                2: drive(1'b1, 2'b00, 1'b0, 1'b1, 4'd6);
                12: drive(1'b1, 2'b01, 1'b0, 1'b0, 4'd0);
                default: idle();
            endcase
            #1;
            exp_v = {m_q ^ f_nq(), m_q, m_st != 0, m_done, f_ready()};
            got_v = {t_vec, bank, busy, done, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL down_wrap cyc %0d got %h exp %h", c, got_v, exp_v);
            end
            if (c >= 3 && c <= 11 && done) ndone++;
            step();
        end
        checks++;
        if (ndone != 2 || bank !== 4'd7 || busy !== 1'b0) begin
            errors++; $display("FAIL down_wrap_end got dones=%0d q=%0d busy=%b exp dones=2 q=7 busy=0", ndone, bank, busy);
        end
    endtask

    task automatic test_stop();
        int ndone = 0;
        int c = 0;
        bit part2 = 0;
        bit fin = 0;
        // clear, start up to 15, stop at 3; then start wrap tc=6 from 4, stop at tc
        while (!fin && c < 60) begin
            if (c == 0) drive(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
            else if (c == 2) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'hF);
            else if (!part2 && m_st == 1 && m_q == 4'd3) drive(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
            else if (part2 && m_st == 0 && c < 20) drive(1'b1, 2'b00, 1'b1, 1'b1, 4'd6);
            else if (part2 && m_st == 1 && m_q == 4'd6) drive(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
            else idle();
            #1;
            exp_v = {m_q ^ f_nq(), m_q, m_st != 0, m_done, f_ready()};
            got_v = {t_vec, bank, busy, done, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL stop cyc %0d got %h exp %h", c, got_v, exp_v);
            end
            if (!part2 && done) ndone++;
            if (part2 && c > 20 && m_st == 0) fin = 1;
            if (!part2 && c == 12) begin
                checks++;
                if (bank !== 4'd4 || busy !== 1'b0 || ndone != 0) begin
                    errors++; $display("FAIL stop_hold got q=%0d busy=%b dones=%0d exp q=4 busy=0 dones=0", bank, busy, ndone);
                end
                part2 = 1;
            end
            if (!fin) step();
            c++;
        end
        checks++;
        if (!fin || bank !== 4'd4 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL stop_at_tc got fin=%b q=%0d done=%b busy=%b exp fin=1 q=4 done=1 busy=0", fin, bank, done, busy);
        end
        idle();
        step();
    endtask

    task automatic test_edge();
        int nd_a = 0;
        int nd_b = 0;
        logic [3:0] q0;
        q0 = m_q;
        for (int c = 0; c < 12; c++) begin
            if (c == 0) drive(1'b1, 2'b00, 1'b1, 1'b0, q0);
            else if (c == 4) drive(1'b1, 2'b00, 1'b0, 1'b1, q0);
            else if (c == 9) drive(1'b1, 2'b01, 1'b0, 1'b0, 4'h0);
            else idle();
            #1;
            exp_v = {m_q ^ f_nq(), m_q, m_st != 0, m_done, f_ready()};
            got_v = {t_vec, bank, busy, done, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL edge cyc %0d got %h exp %h", c, got_v, exp_v);
            end
            if (c < 4 && done) nd_a++;
            if (c >= 5 && c <= 8 && done) nd_b++;
            step();
        end
        checks++;
        if (nd_a != 1 || nd_b != 3 || bank !== q0) begin
            errors++; $display("FAIL edge_tc got dones=%0d/%0d q=%h exp dones=1/3 q=%h", nd_a, nd_b, bank, q0);
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        while (c < 10 && !(m_st == 1 && m_q == 4'd2)) begin
            if (c == 0) drive(1'b1, 2'b11, 1'b0, 1'b0, 4'h0);
            else if (c == 2) drive(1'b1, 2'b00, 1'b1, 1'b0, 4'hF);
            else idle();
            step();
            c++;
        end
        idle();
        rst_n = 1'b0;
        #1;
        checks++;
        if (t_vec !== 4'h0 || busy !== 1'b0 || done !== 1'b0 || bank !== 4'd2) begin
            errors++; $display("FAIL reset_mid got t=%h busy=%b done=%b q=%0d exp t=0 busy=0 done=0 q=2", t_vec, busy, done, bank);
        end
        @(negedge clk);
        checks++;
        if (bank !== 4'd2 || t_vec !== 4'h0) begin
            errors++; $display("FAIL reset_mid_hold got q=%0d t=%h exp q=2 t=0", bank, t_vec);
        end
        rst_n = 1'b1;
        model_reset();
        m_q = bank;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            #1;
            exp_v = {m_q ^ f_nq(), m_q, m_st != 0, m_done, f_ready()};
            got_v = {t_vec, bank, busy, done, cmd_ready};
            checks++;
            if (got_v !== exp_v) begin
                errors++; $display("FAIL random cyc %0d got %h exp %h", c, got_v, exp_v);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_up_halt();
        test_down_wrap();
        test_stop();
        test_edge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
